nofx2_event_unpacker: RTL and testbench

Read-side counterpart of the event-buffer packer. Pulls 32-bit words from the non-FWFT event FIFO (read latency 1 cycle), splits each into two 16-bit frame words, undoes the per-word byte swap, and discards the pad half-word written after odd-length frames. Emits a 16-bit frame stream with valid/ready handshake and start/end-of-frame markers. Used for on-board loopback, readback checking, and any non-Xillybus consumer of the event stream.

---
 rtl/nofx2_pkg.sv | 16 +
 rtl/nofx2_word_buf.sv | 64 ++++++
 rtl/nofx2_event_unpacker.sv | 104 ++++++++++
 tb/tb_nofx2_event_unpacker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nofx2_pkg.sv
// rtl/nofx2_pkg.sv - shared parser state, frame-word width and byte-swap helper
package nofx2_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        ST_TYPE,
        ST_LEN,
        ST_DATA
    } parse_state_t;

    function automatic logic [FRAME_W-1:0] swap16(input logic [FRAME_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/nofx2_word_buf.sv
// rtl/nofx2_word_buf.sv - 2-entry FIFO word buffer presenting one half-word at a time
module nofx2_word_buf
    import nofx2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        fifo_dat,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    output logic               half_valid,
    output logic [FRAME_W-1:0] half_dat,
    output logic               half_hi,
    input  logic               pop,
    input  logic               drop_hi
);

    logic [31:0] mem [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        in_flight;
    logic        hp;
    logic        rd_en_q;
    logic        pop_entry;
    logic [1:0]  occ;

    assign half_valid = (count != 2'd0);
    assign half_dat   = hp ? mem[head][31:16] : mem[head][15:0];
    assign half_hi    = hp;

    // An entry frees up on the cycle its last half is consumed (or its pad is dropped),
    // so the refill read can go out immediately and pad drops cost no output cycle.
    assign pop_entry = pop && (hp || drop_hi);
    assign occ       = count + {1'b0, in_flight} - {1'b0, pop_entry};
    assign fifo_rd   = rd_en_q && !fifo_empty && (occ < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            in_flight <= 1'b0;
            hp        <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_en_q   <= 1'b1;
            in_flight <= fifo_rd;
            count     <= count + {1'b0, in_flight} - {1'b0, pop_entry};
            if (in_flight) begin
                mem[tail] <= fifo_dat;
                tail      <= ~tail;
            end
            if (pop_entry) begin
                head <= ~head;
                hp   <= 1'b0;
            end else if (pop) begin
                hp <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nofx2_event_unpacker.sv
// rtl/nofx2_event_unpacker.sv - event FIFO to 16-bit frame stream unpacker
// Optional NOFX2_UNPACK_SWAP_EN: restore original byte order on dat_o.
module nofx2_event_unpacker
    import nofx2_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic [31:0]        fifo_dat_i,
    input  logic               fifo_empty_i,
    output logic               fifo_rd_o,
    output logic [FRAME_W-1:0] dat_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               sof_o,
    output logic               eof_o,
    output logic               frame_err_o,
    output logic [15:0]        frame_count_o
);

    logic               half_valid;
    logic [FRAME_W-1:0] half_dat;
    logic               half_hi;
    logic               out_adv;
    logic               take;
    logic               drop_hi;
    logic [FRAME_W-1:0] parsed;
    logic [FRAME_W-1:0] emit_dat;
    logic [15:0]        remaining;
    parse_state_t       state;

    nofx2_word_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n_i),
        .fifo_dat   (fifo_dat_i),
        .fifo_empty (fifo_empty_i),
        .fifo_rd    (fifo_rd_o),
        .half_valid (half_valid),
        .half_dat   (half_dat),
        .half_hi    (half_hi),
        .pop        (take),
        .drop_hi    (drop_hi)
    );

    assign out_adv = !valid_o || ready_i;
    assign take    = half_valid && out_adv;
    assign parsed  = swap16(half_dat);
`ifdef NOFX2_UNPACK_SWAP_EN
    assign emit_dat = parsed;
`else
    assign emit_dat = half_dat;
`endif
    // Last payload word landing in a low half means the high half is packer pad.
    assign drop_hi = take && (state == ST_DATA) && (remaining == 16'd1) && !half_hi;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_o         <= '0;
            valid_o       <= 1'b0;
            sof_o         <= 1'b0;
            eof_o         <= 1'b0;
            frame_err_o   <= 1'b0;
            frame_count_o <= 16'd0;
            remaining     <= 16'd0;
            state         <= ST_TYPE;
        end else begin
            frame_err_o <= 1'b0;
            if (out_adv) begin
                valid_o <= take;
            end
            if (take) begin
                dat_o <= emit_dat;
                sof_o <= 1'b0;
                eof_o <= 1'b0;
                case (state)
                    ST_TYPE: begin
                        sof_o <= 1'b1;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        remaining <= parsed;
                        if (parsed == 16'd0) begin
                            eof_o         <= 1'b1;
                            frame_err_o   <= 1'b1;
                            frame_count_o <= frame_count_o + 16'd1;
                            state         <= ST_TYPE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            eof_o         <= 1'b1;
                            frame_count_o <= frame_count_o + 16'd1;
                            state         <= ST_TYPE;
                        end
                    end
                    default: state <= ST_TYPE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nofx2_event_unpacker.sv
// tb/tb_nofx2_event_unpacker.sv - self-checking bench for nofx2_event_unpacker
module tb_nofx2_event_unpacker;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] fifo_dat_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_rd_o;
    logic [15:0] dat_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        sof_o;
    logic        eof_o;
    logic        frame_err_o;
    logic [15:0] frame_count_o;

    always #5 clk = ~clk;

    nofx2_event_unpacker dut (
        .clk           (clk),
        .rst_n_i       (rst_n_i),
        .fifo_dat_i    (fifo_dat_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rd_o     (fifo_rd_o),
        .dat_o         (dat_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .sof_o         (sof_o),
        .eof_o         (eof_o),
        .frame_err_o   (frame_err_o),
        .frame_count_o (frame_count_o)
    );

    typedef struct packed {
        logic [15:0] dat;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    int          acc_times[$];
    int          checks = 0;
    int          errors = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    int          frames_exp = 0;
    int          rd_viol = 0;
    int          cyc = 0;
    bit          rand_ready = 1'b0;
    bit          stalled = 1'b0;
    logic [15:0] held_dat;
    logic        held_sof;
    logic        held_eof;

    function automatic logic [15:0] bswap(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [15:0] shown(input logic [15:0] w);
`ifdef NOFX2_UNPACK_SWAP_EN
        return w;
`else
        return bswap(w);
`endif
    endfunction

    // Non-FWFT FIFO: dout updates one cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_o) begin
            if (fifo_q.size() == 0) rd_viol++;
            else fifo_dat_i <= fifo_q.pop_front();
        end
        fifo_empty_i <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n_i) begin
            if (stalled) begin
                checks++;
                assert (valid_o === 1'b1 && dat_o === held_dat && sof_o === held_sof && eof_o === held_eof)
                else begin
                    errors++;
                    $error("FAIL stall_hold got v=%b dat=%h sof=%b eof=%b exp v=1 dat=%h sof=%b eof=%b",
                           valid_o, dat_o, sof_o, eof_o, held_dat, held_sof, held_eof);
                end
            end
            if (frame_err_o) err_seen++;
            ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid_o && ready_i) begin
                acc_times.push_back(cyc);
                checks++;
                assert (exp_q.size() > 0)
                else begin
                    errors++;
                    $error("FAIL extra_word got dat=%h sof=%b eof=%b exp none", dat_o, sof_o, eof_o);
                end
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({dat_o, sof_o, eof_o} === e)
                    else begin
                        errors++;
                        $error("FAIL word got dat=%h sof=%b eof=%b exp dat=%h sof=%b eof=%b",
                               dat_o, sof_o, eof_o, e.dat, e.sof, e.eof);
                    end
                end
            end
            stalled  = valid_o && !ready_i;
            held_dat = dat_o;
            held_sof = sof_o;
            held_eof = eof_o;
        end else begin
            stalled = 1'b0;
            ready_i = 1'b1;
        end
    end

    // Packer model: frame words laid out pairwise, pad after odd totals, each half byte-swapped.
    task automatic send_frame(input logic [15:0] typ, input logic [15:0] len, input logic [15:0] pad);
        logic [15:0] w[$];
        logic [15:0] hi;
        exp_t        e;
        w.push_back(typ);
        w.push_back(len);
        for (int i = 0; i < int'(len); i++) w.push_back(16'($urandom));
        for (int i = 0; i < w.size(); i++) begin
            e.dat = shown(w[i]);
            e.sof = (i == 0);
            e.eof = (i == w.size() - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < w.size(); i += 2) begin
            hi = (i + 1 < w.size()) ? w[i+1] : pad;
            fifo_q.push_back({bswap(hi), bswap(w[i])});
        end
        frames_exp++;
        if (len == 16'd0) err_exp++;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0)
        else begin errors++; $error("FAIL %s_drain left=%0d exp=0", tag, exp_q.size()); end
        checks++;
        assert (frame_count_o === 16'(frames_exp))
        else begin errors++; $error("FAIL %s_frame_count got=%0d exp=%0d", tag, frame_count_o, frames_exp); end
        checks++;
        assert (err_seen == err_exp)
        else begin errors++; $error("FAIL %s_frame_err got=%0d exp=%0d", tag, err_seen, err_exp); end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert ({fifo_rd_o, valid_o, sof_o, eof_o, frame_err_o} === 5'b0 && dat_o === 16'h0 && frame_count_o === 16'h0)
        else begin
            errors++;
            $error("FAIL %s got rd=%b v=%b sof=%b eof=%b err=%b dat=%h cnt=%h exp all 0",
                   tag, fifo_rd_o, valid_o, sof_o, eof_o, frame_err_o, dat_o, frame_count_o);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        fifo_q.push_back(32'h1234_5678);
        repeat (2) @(negedge clk);
        checks++;
        assert (fifo_rd_o === 1'b0)
        else begin errors++; $error("FAIL rd_in_reset got=%b exp=0", fifo_rd_o); end
        fifo_q.delete();
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);

        send_frame(16'h4500, 16'h000D, 16'hBEEF);
        wait_drain("odd_frame");

        send_frame(16'h1111, 16'd2, 16'h0000);
        send_frame(16'h2222, 16'd1, 16'hBEEF);
        wait_drain("back_to_back");

        acc_times.delete();
        send_frame(16'h3333, 16'd1, 16'hBEEF);
        send_frame(16'h4444, 16'd1, 16'hBEEF);
        send_frame(16'h5555, 16'd3, 16'hBEEF);
        wait_drain("pad_drop");
        checks++;
        assert (acc_times.size() == 11 && acc_times[10] - acc_times[0] == 10)
        else begin errors++; $error("FAIL throughput got n=%0d exp n=11 span=10", acc_times.size()); end

        send_frame(16'h6600, 16'd0, 16'h0000);
        send_frame(16'h6601, 16'd2, 16'h0000);
        wait_drain("len_zero");

        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            send_frame(16'($urandom), 16'($urandom_range(0, 9)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_drain("random");
        rand_ready = 1'b0;

        send_frame(16'h7700, 16'd20, 16'h0000);
        for (int n = 0; n < 200 && exp_q.size() > 15; n++) @(negedge clk);
        checks++;
        assert (exp_q.size() <= 15)
        else begin errors++; $error("FAIL mid_frame_reach left=%0d exp<=15", exp_q.size()); end
        rst_n_i = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        frames_exp = 0;
        err_exp = 0;
        err_seen = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n_i = 1'b1;
        send_frame(16'h4500, 16'd3, 16'hBEEF);
        wait_drain("after_reset");

        checks++;
        assert (rd_viol == 0)
        else begin errors++; $error("FAIL rd_while_empty got=%0d exp=0", rd_viol); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
